// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / periodic modes, terminal-count pulse and sticky expired flag.
// Optional input prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  periodic,
  input  logic                  enable,
  input  logic                  stop,
`ifdef DOWN_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      counter_out,
  output logic                  zero,
  output logic                  busy,
  output logic                  expired
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             zero_d;
  logic             tick;

  if (WIDTH == 0 || PRESCALE_W == 0) begin : g_param_chk
    $error("down_timer: WIDTH and PRESCALE_W must be nonzero");
  end

`ifdef DOWN_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  assign tick = enable && (psc_q == prescale);

  // Prescaler advances only on enabled RUN cycles; load/stop realign it.
  always_comb begin
    psc_d = psc_q;
    if (stop || load) begin
      psc_d = '0;
    end else if (state_q == RUN && enable) begin
      psc_d = (psc_q == prescale) ? '0 : psc_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) psc_q <= '0;
    else       psc_q <= psc_d;
  end
`else
  assign tick = enable;
`endif

  // Next-state and datapath: stop > load > tick.
  always_comb begin
    state_d  = state_q;
    count_d  = counter_out;
    reload_d = reload_q;
    mode_d   = mode_q;
    zero_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      reload_d = load_value;
      mode_d   = periodic;
      count_d  = load_value;
      if (load_value != '0) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        zero_d  = 1'b1;
      end
    end else if (state_q == RUN && tick) begin
      if (counter_out == WIDTH'(1)) begin
        zero_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end else begin
        count_d = counter_out - WIDTH'(1);
      end
    end
  end

  // busy/expired registered from next state so they track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_out <= '0;
      reload_q    <= '0;
      mode_q      <= 1'b0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_out <= count_d;
      reload_q    <= reload_d;
      mode_q      <= mode_d;
      zero        <= zero_d;
      busy        <= (state_d == RUN);
      expired     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Randomized self-checking bench for down_timer against an elapsed-tick reference model.
module tb_down_timer;
  localparam int unsigned W  = 4;
  localparam int unsigned PW = 4;

  logic         clk = 1'b0;
  logic         reset, load, periodic, enable, stop;
  logic [W-1:0] load_value;
  logic [W-1:0] counter_out;
  logic         zero, busy, expired;
`ifdef DOWN_TIMER_PRESCALE_EN
  logic [PW-1:0] prescale = '0;
`endif

  down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .periodic(periodic), .enable(enable), .stop(stop),
`ifdef DOWN_TIMER_PRESCALE_EN
    .prescale(prescale),
`endif
    .counter_out(counter_out), .zero(zero), .busy(busy), .expired(expired)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Model: timer described by loaded value, mode and ticks elapsed since load.
  bit m_loaded, m_per, m_zero;
  int m_val, m_ticks, m_en, m_div;

  function automatic int exp_count();
    if (!m_loaded || m_val == 0) return 0;
    if (m_per) return m_val - (m_ticks % m_val);
    return (m_ticks >= m_val) ? 0 : m_val - m_ticks;
  endfunction

  function automatic bit exp_busy();
    return m_loaded && m_val != 0 && (m_per || m_ticks < m_val);
  endfunction

  function automatic void model_reset();
    m_loaded = 0; m_per = 0; m_zero = 0;
    m_val = 0; m_ticks = 0; m_en = 0; m_div = 1;
  endfunction

  function automatic void model_step(bit ld, int v, bit per, bit en, bit st, int div);
    bit b;
    b = exp_busy();
    m_zero = 0;
    if (st) begin
      m_loaded = 0; m_en = 0;
    end else if (ld) begin
      m_loaded = 1; m_val = v; m_per = per; m_ticks = 0; m_en = 0;
      m_zero = (v == 0); m_div = div;
    end else if (b && en) begin
      m_en++;
      if (m_en % m_div == 0) begin
        m_ticks++;
        if (m_ticks % m_val == 0) m_zero = 1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_cnt"},  int'(counter_out), exp_count());
    check({tag, "_zero"}, int'(zero),        int'(m_zero));
    check({tag, "_busy"}, int'(busy),        int'(exp_busy()));
    check({tag, "_exp"},  int'(expired),     int'(m_loaded && !exp_busy()));
  endtask

  // Drives one cycle of inputs (called just after a negedge), steps the model, checks at next negedge.
  task automatic cycle(input string tag, input bit ld, input int v, input bit per,
                       input bit en, input bit st, input int psc);
    int div;
    div = 1;
`ifdef DOWN_TIMER_PRESCALE_EN
    if (ld) prescale = PW'(psc);
    div = int'(prescale) + 1;
`endif
    load = ld; load_value = W'(v); periodic = per; enable = en; stop = st;
    @(posedge clk);
    model_step(ld, v, per, en, st, div);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 0; load_value = '0; periodic = 0; enable = 0; stop = 0;
    model_reset();
    #2;
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count, then enabled idle cycles without load.
    cycle("ld9", 1, 9, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("run9", 0, 0, 0, 1, 0, 0);
    check("pre_rst_cnt", int'(counter_out), 6);
    do_reset("midrst");
    for (int i = 0; i < 3; i++) cycle("post_rst", 0, 0, 0, 1, 0, 0);

    // One-shot of 3.
    cycle("os_ld", 1, 3, 0, 1, 0, 0);
    check("os_first", int'(counter_out), 3);
    for (int i = 0; i < 5; i++) cycle("os", 0, 0, 0, 1, 0, 0);
    check("os_hold", int'(counter_out), 0);
    check("os_expired", int'(expired), 1);

    // Periodic of 2.
    cycle("per_ld", 1, 2, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle("per", 0, 0, 0, 1, 0, 0);

    // Enable gating, then load+stop together.
    cycle("en_ld", 1, 5, 0, 1, 0, 0);
    cycle("en1", 0, 0, 0, 1, 0, 0);
    cycle("en0", 0, 0, 0, 0, 0, 0);
    cycle("en1b", 0, 0, 0, 1, 0, 0);
    check("gate_cnt", int'(counter_out), 3);
    cycle("ldstop", 1, 7, 0, 1, 1, 0);
    check("ldstop_cnt", int'(counter_out), 0);
    check("ldstop_zero", int'(zero), 0);

    // Boundaries: load 0, full-scale load, reload at terminal.
    cycle("ld0", 1, 0, 1, 1, 0, 0);
    check("ld0_zero", int'(zero), 1);
    cycle("ld0_after", 0, 0, 0, 1, 0, 0);
    cycle("ld15", 1, 15, 0, 1, 0, 0);
    for (int i = 0; i < 14; i++) cycle("run15", 0, 0, 0, 1, 0, 0);
    check("at_one", int'(counter_out), 1);
    cycle("reld4", 1, 4, 0, 1, 0, 0);
    check("reld4_cnt", int'(counter_out), 4);
    check("reld4_zero", int'(zero), 0);
    for (int i = 0; i < 4; i++) cycle("run4", 0, 0, 0, 1, 0, 0);
    check("run4_zero", int'(zero), 1);

`ifdef DOWN_TIMER_PRESCALE_EN
    // Prescale 2: terminal count six cycles after load.
    cycle("psc_ld", 1, 2, 0, 1, 0, 2);
    for (int i = 0; i < 6; i++) cycle("psc", 0, 0, 0, 1, 0, 2);
    check("psc_zero6", int'(zero), 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle("rnd", ($urandom_range(7) == 0), $urandom_range(15), $urandom_range(1),
            ($urandom_range(3) != 0), ($urandom_range(23) == 0), $urandom_range(3));
      if (i == 300) begin
        @(negedge clk);
        do_reset("rnd_rst");
        @(negedge clk);
        check_all("rnd_post_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer. It is the counterpart of the team's free-running 4-bit up counter: it counts a loaded value down to zero instead of up from zero. It supports one-shot and periodic (auto-reload) modes, a registered terminal-count pulse and a sticky expired flag. It sits beside the up counter in timing and control datapaths, generating timeouts and periodic ticks for downstream FSMs.

Parameters:
WIDTH, 4, counter width in bits
PRESCALE_W, 4, prescaler width in bits (used only when PRESCALE_EN is defined)

Ports:
clk  input  1  clock input; all state updates on posedge
reset  input  1  asynchronous, active-high reset
load  input  1  start/restart: capture load_value and periodic
load_value  input  WIDTH  start count and reload value
periodic  input  1  mode select, sampled only when load=1: 1=auto-reload, 0=one-shot
enable  input  1  count permit; count holds when low
stop  input  1  abort the timer; return to IDLE
counter_out  output  WIDTH  current count
zero  output  1  one-cycle registered terminal-count pulse
busy  output  1  high while in RUN
expired  output  1  sticky; high in DONE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; counter_out=0; reload_reg=0; mode_reg=0; zero=0; busy=0; expired=0.
- States: IDLE, RUN, DONE. busy=(state==RUN). expired=(state==DONE). Both are decoded from registered state.
- tick = enable (see Optional Feature).
- Priority each cycle: stop > load > tick.
- stop=1 in any state: next state IDLE; counter_out<=0; zero<=0.
- load=1 in any state, stop=0:
  - reload_reg<=load_value; mode_reg<=periodic; counter_out<=load_value.
  - If load_value!=0: next state RUN.
  - If load_value==0: next state DONE and zero<=1. A load of 0 never enters RUN, even with periodic=1.
  - A load in RUN restarts the timer with the new value. No zero pulse is generated for the aborted run.
- RUN, tick=1, counter_out>1: counter_out<=counter_out-1.
- RUN, tick=1, counter_out==1:
  - zero<=1.
  - If mode_reg=1: counter_out<=reload_reg and the state stays RUN. The period is exactly reload_reg ticks, and counter_out never shows 0.
  - If mode_reg=0: counter_out<=0; next state DONE.
- RUN, tick=0: counter_out holds.
- zero is high for exactly one cycle per terminal count and is 0 in every other cycle. It is registered, and it asserts in the same cycle counter_out first shows its post-terminal value.
- DONE: counter_out holds 0; expired stays high until load or stop. tick has no effect.
- IDLE: counter_out holds; tick has no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement below 0 cannot occur, because the value 1 is the terminal case.
- Reset asserted mid-run: all outputs go immediately (asynchronously) to their reset values. Counting resumes only after a new load.

Optional Feature:
Macro DOWN_TIMER_PRESCALE_EN.
- Defined:
  - Adds input prescale [PRESCALE_W-1:0] and an internal prescaler counter psc.
  - tick = enable && (psc==prescale).
  - On enable=1 in RUN: psc<=0 when psc==prescale, else psc<=psc+1.
  - psc clears to 0 on reset, load or stop, and holds while enable=0.
  - Effective tick rate is one per (prescale+1) enabled cycles. prescale=0 behaves identically to the feature being absent.
- Undefined: no prescale port, no psc register; tick = enable.

Test Plan:
1. Reset mid-count: load 4'd9, run 3 ticks, assert reset -> counter_out=0, busy=0, expired=0, zero=0 immediately; with enable=1 and no load afterwards, counter_out stays 0.
2. One-shot: load 4'd3, periodic=0, enable=1 constant -> counter_out 3,2,1,0 on consecutive cycles; zero=1 only in the cycle counter_out=0; then expired=1, busy=0, counter_out holds 0.
3. Periodic: load 4'd2, periodic=1, enable=1 -> counter_out 2,1,2,1,...; zero pulses every 2nd cycle; busy stays 1; expired stays 0.
4. Enable gating and priority: load 4'd5; toggle enable 1,0,1 -> count decrements only on enable=1 cycles. Assert load (value 4'd7) and stop together in RUN -> IDLE, counter_out=0, no zero pulse.
5. Boundaries: load 4'd0, periodic=1 -> next cycle DONE, zero=1 for one cycle. Load 4'd15 -> 15 ticks to terminal. Reload 4'd4 at counter_out=1 in the same cycle as tick -> load wins: counter_out=4, no zero.
6. DOWN_TIMER_PRESCALE_EN defined, prescale=2, load 4'd2, enable=1 -> counter_out decrements every 3rd cycle; zero asserts 6 cycles after load.
